dpram_stream_reader: RTL and testbench
======================================

# dpram_stream_reader

Read-side sequencer for the dual-port RAM wrapper: accepts a (base, length) command, drives the RAM read port (enb/addrb), absorbs the fixed N_DELAY read latency, and presents the words as a valid/ready stream with a last marker. Sits between the layer's buffer RAMs (feature/weight dpram instances) and the compute datapath. A small internal FIFO sized by credits guarantees no word is lost under downstream backpressure.

## Interface
- DW, 64, data word width; must match the attached RAM
- AW, 8, RAM address width
- N_DELAY, 1, RAM read latency in cycles (enb to dob valid); ≥1
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ N_DELAY+2 for one-word/cycle throughput, ≥ N_DELAY+1 for correctness
- clk  in  1  sole clock; one clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_base  in  AW  first read address
- cmd_len  in  AW+1  word count, 0..2^AW
- enb  out  1  RAM read enable
- addrb  out  AW  RAM read address
- dob  in  DW  RAM read data, valid N_DELAY cycles after enb
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accepts
- m_data  out  DW  stream word
- m_last  out  1  marks final word of command
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid: latch base into addr counter, len into remaining. len≠0 → ISSUE; len=0 → stay IDLE, done pulses next cycle, no stream output.
- ISSUE: enb=1 when remaining>0 and (fifo_count + inflight) < FIFO_DEPTH (registered counts; same-cycle pop not credited). Each issue: addrb=addr, addr+1 mod 2^AW (wraps 2^AW−1→0), remaining−1. Issue with remaining=1 → DRAIN.
- Latency pipe: N_DELAY-deep shift register of {valid, last} flags; flag exiting pipe writes dob into FIFO that cycle. last=1 on the issue where remaining=1.
- inflight = number of set valid flags in pipe (0..N_DELAY).
- DRAIN: no issues; on handshake (m_valid & m_ready & m_last) → IDLE, done=1 next cycle.
- Stream: m_valid = FIFO non-empty; m_data/m_last = FIFO head; pop on m_valid & m_ready. m_data held stable while m_valid & !m_ready.
- FIFO overflow impossible by credit rule; an overflow write is an assertion failure.
- enb=0 and addrb holds last value whenever not issuing.
- Write port of the RAM is not touched; caller guarantees region is not being written during a command.

## Timing
- Reset values: cmd_ready=1, enb=0, addrb=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0; FIFO, pipe, counters cleared.
- Command accepted in cycle 0 → first enb in cycle 1 → dob valid cycle 1+N_DELAY → m_valid cycle 2+N_DELAY (N_DELAY=1: cycle 3).
- With m_ready=1 and FIFO_DEPTH ≥ N_DELAY+2: one word per cycle, len words end at cycle len+1+N_DELAY; done in following cycle, cmd_ready=1 same cycle as done.
- Backpressure: issue stalls once fifo_count+inflight reaches FIFO_DEPTH; resumes cycle after pop drops the sum.
- Reset mid-command: immediate return to IDLE, in-flight and queued words discarded, no done.
- cmd_valid while busy ignored (cmd_ready=0).

## Structure
- Shared header dpram_reader_defs.vh: state encodings (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2).
- One sub-module: sync_fifo_reg (register-based FIFO, params DW+1, FIFO_DEPTH; ports push/pop/full/empty/count, async active-high reset).
- Counter widths: count/inflight use $clog2(FIFO_DEPTH+1).

## Test plan
- base=0x10, len=5, m_ready=1, N_DELAY=1 → enb cycles 1–5 at addrb 0x10..0x14, m_valid cycles 3–7 with data of those addresses, m_last in cycle 7, done in cycle 8.
- base=0xFE, len=4 → addrb 0xFE,0xFF,0x00,0x01; stream in that order.
- len=5, m_ready=0 throughout → exactly 4 enb pulses then stall; raising m_ready drains all 5 words in order, none duplicated or dropped.
- len=0 → cmd accepted, no enb, no m_valid, done pulse cycle 1.
- Reset asserted while 2 words queued → all outputs to reset values same cycle; next command runs cleanly from its base.
- Random m_ready toggling, N_DELAY=3, FIFO_DEPTH=5, len=256 → scoreboard matches RAM contents, m_last only on word 256, cmd_valid during busy ignored.

Source files
------------

// File: rtl/dpram_stream_reader_pkg.sv
// Shared types for the dual-port RAM stream reader.
package dpram_stream_reader_pkg;

    // Sequencer states; encodings are shared with anything that observes the FSM.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/dpram_stream_reader_sync_fifo_reg.sv
// Register-based synchronous FIFO with occupancy count; holds {last, data} words.
module sync_fifo_reg #(
    parameter int unsigned DW    = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [DW-1:0]                  wdata,
    input  logic                           pop,
    output logic [DW-1:0]                  rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Status flags and guarded push/pop strobes.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        count   = count_q;
        rdata   = mem_q[rd_ptr_q];
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // The issuer's credit scheme must never let a word arrive with no room for it.
    overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full))
        else $error("sync_fifo_reg overflow write");

endmodule

// File: rtl/dpram_stream_reader.sv
// Read-side sequencer: turns a (base, length) command into RAM reads and a valid/ready stream.
module dpram_stream_reader
    import dpram_stream_reader_pkg::*;
#(
    parameter int unsigned DW         = 64,
    parameter int unsigned AW         = 8,
    parameter int unsigned N_DELAY    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW:0]   cmd_len,
    output logic          enb,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] dob,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DepthW = (CW+1)'(FIFO_DEPTH);

    state_e             state_q, state_d;
    logic [AW-1:0]      addr_q, addrb_q;
    logic [AW:0]        rem_q;
    logic [N_DELAY-1:0] pipe_v_q, pipe_l_q;
    logic               done_q;
    logic [CW-1:0]      fifo_count, inflight;
    logic               fifo_full, fifo_empty;
    logic [DW:0]        fifo_out;
    logic               issue, issue_last, accept, pop, last_hs;

    // Credit check: registered FIFO occupancy plus reads still in the RAM pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            inflight = inflight + CW'(pipe_v_q[i]);
        end
        accept     = (state_q == StIdle) && cmd_valid;
        issue      = (state_q == StIssue) && (rem_q != '0) && !fifo_full &&
                     (({1'b0, fifo_count} + {1'b0, inflight}) < DepthW);
        issue_last = issue && (rem_q == (AW+1)'(1));
        pop        = m_valid && m_ready;
        last_hs    = pop && m_last;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid && (cmd_len != '0)) state_d = StIssue;
            StIssue: if (issue_last) state_d = StDrain;
            StDrain: if (last_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; addrb shows the live address only while issuing.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        enb       = issue;
        addrb     = issue ? addr_q : addrb_q;
        done      = done_q;
        m_valid   = !fifo_empty;
        m_last    = fifo_out[DW];
        m_data    = fifo_out[DW-1:0];
    end

    // Address/length counters, held read address and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            rem_q   <= '0;
            addrb_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (accept && (cmd_len == '0)) || ((state_q == StDrain) && last_hs);
            if (accept) begin
                addr_q <= cmd_base;
                rem_q  <= cmd_len;
            end else if (issue) begin
                addr_q  <= addr_q + AW'(1);
                rem_q   <= rem_q - (AW+1)'(1);
                addrb_q <= addr_q;
            end
        end
    end

    // Latency pipe: flags travel alongside the RAM read and mark when dob is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v_q <= '0;
            pipe_l_q <= '0;
        end else begin
            pipe_v_q[0] <= issue;
            pipe_l_q[0] <= issue_last;
            for (int i = 1; i < N_DELAY; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_l_q[i] <= pipe_l_q[i-1];
            end
        end
    end

    sync_fifo_reg #(
        .DW    (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_v_q[N_DELAY-1]),
        .wdata ({pipe_l_q[N_DELAY-1], dob}),
        .pop   (pop),
        .rdata (fifo_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Scoreboard bench: instance A (N_DELAY=1, depth 4) directed, instance B (N_DELAY=3, depth 5) random.
module tb_dpram_stream_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [256];

    // Instance A signals
    logic        cmd_valid_a = 0, cmd_ready_a, enb_a, m_valid_a, m_ready_a = 0, m_last_a;
    logic        busy_a, done_a;
    logic [7:0]  cmd_base_a = 0, addrb_a;
    logic [8:0]  cmd_len_a = 0;
    logic [63:0] dob_a, m_data_a;
    // Instance B signals
    logic        cmd_valid_b = 0, cmd_ready_b, enb_b, m_valid_b, m_ready_b = 0, m_last_b;
    logic        busy_b, done_b;
    logic [7:0]  cmd_base_b = 0, addrb_b;
    logic [8:0]  cmd_len_b = 0;
    logic [63:0] dob_b, m_data_b, rb1, rb2;

    logic [64:0] exp_q_a[$], exp_q_b[$];
    logic [7:0]  exp_addr_a[$];
    int          enb_cnt_a = 0;
    logic        junk_b = 0;

    dpram_stream_reader #(.DW(64), .AW(8), .N_DELAY(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_base(cmd_base_a), .cmd_len(cmd_len_a), .enb(enb_a), .addrb(addrb_a), .dob(dob_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a), .m_last(m_last_a),
        .busy(busy_a), .done(done_a)
    );

    dpram_stream_reader #(.DW(64), .AW(8), .N_DELAY(3), .FIFO_DEPTH(5)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_base(cmd_base_b), .cmd_len(cmd_len_b), .enb(enb_b), .addrb(addrb_b), .dob(dob_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b),
        .busy(busy_b), .done(done_b)
    );

    // RAM read ports: latency 1 for A, latency 3 for B.
    always @(posedge clk) begin
        dob_a <= mem[addrb_a];
        rb1   <= mem[addrb_b];
        rb2   <= rb1;
        dob_b <= rb2;
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Expected words come straight from RAM contents in address order, last on the final one.
    task automatic expect_cmd(input bit is_a, input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            if (is_a) begin
                exp_q_a.push_back({(i == len - 1), mem[a]});
                exp_addr_a.push_back(a);
            end else begin
                exp_q_b.push_back({(i == len - 1), mem[a]});
            end
        end
    endtask

    // Monitor A: read addresses, stream words and stability under backpressure.
    initial begin
        logic        hold;
        logic [64:0] prev;
        hold = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (enb_a) begin
                    enb_cnt_a++;
                    if (exp_addr_a.size() == 0) fail("A unexpected enb");
                    else check("A addrb", 65'(addrb_a), 65'(exp_addr_a.pop_front()));
                end
                if (hold) check("A hold stable", {m_valid_a, m_last_a, m_data_a}, {1'b1, prev});
                if (m_valid_a && m_ready_a) begin
                    if (exp_q_a.size() == 0) fail("A unexpected word");
                    else check("A word", {m_last_a, m_data_a}, exp_q_a.pop_front());
                end
                hold = m_valid_a && !m_ready_a;
                prev = {m_last_a, m_data_a};
            end
        end
    end

    // Monitor B: stream words, stability and ignored commands while busy.
    initial begin
        logic        hold;
        logic [64:0] prev;
        hold = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (junk_b) check("B cmd_ready while busy", 65'(cmd_ready_b), 65'(0));
                if (hold) check("B hold stable", {m_valid_b, m_last_b, m_data_b}, {1'b1, prev});
                if (m_valid_b && m_ready_b) begin
                    if (exp_q_b.size() == 0) fail("B unexpected word");
                    else check("B word", {m_last_b, m_data_b}, exp_q_b.pop_front());
                end
                hold = m_valid_b && !m_ready_b;
                prev = {m_last_b, m_data_b};
            end
        end
    end

    logic [31:0] tr_enb, tr_mv, tr_ml, tr_dn, tr_rdy;

    // Cycle 0 is the cycle cmd_valid_a is high; records per-cycle flags of A.
    task automatic trace_a(input int n);
        tr_enb = 0; tr_mv = 0; tr_ml = 0; tr_dn = 0; tr_rdy = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tr_enb[k] = enb_a;
            tr_mv[k]  = m_valid_a;
            tr_ml[k]  = m_last_a;
            tr_dn[k]  = done_a;
            tr_rdy[k] = cmd_ready_a;
            @(posedge clk);
            #1;
            if (k == 0) cmd_valid_a = 0;
        end
    endtask

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] v;
        v = 0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic issue_a(input logic [7:0] base, input int len);
        expect_cmd(1, base, len);
        cmd_base_a  = base;
        cmd_len_a   = 9'(len);
        cmd_valid_a = 1;
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, " cmd_ready"}, 65'(cmd_ready_a), 65'(1));
        check({tag, " enb"}, 65'(enb_a), 65'(0));
        check({tag, " addrb"}, 65'(addrb_a), 65'(0));
        check({tag, " m_valid"}, 65'(m_valid_a), 65'(0));
        check({tag, " m_data"}, 65'(m_data_a), 65'(0));
        check({tag, " m_last"}, 65'(m_last_a), 65'(0));
        check({tag, " busy"}, 65'(busy_a), 65'(0));
        check({tag, " done"}, 65'(done_a), 65'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int len, e0, n;
        logic [7:0] base;
        bit got;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};

        #12;
        check_outputs_reset("reset");
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Basic command with full-rate drain and exact cycle timing.
        m_ready_a = 1;
        issue_a(8'h10, 5);
        n = 12;
        trace_a(n);
        check("t1 enb cycles", 65'(tr_enb), 65'(win(1, 5)));
        check("t1 m_valid cycles", 65'(tr_mv), 65'(win(1 + 1 + 1, 5 + 1 + 1)));
        check("t1 m_last cycle", 65'(tr_ml), 65'(win(7, 7)));
        check("t1 done cycle", 65'(tr_dn), 65'(win(8, 8)));
        check("t1 cmd_ready cycles", 65'(tr_rdy), 65'(win(0, 0) | win(8, n - 1)));
        check("t1 scoreboard empty", 65'(exp_q_a.size()), 65'(0));

        // Address wrap across the top of the RAM.
        issue_a(8'hFE, 4);
        trace_a(10);
        check("t2 scoreboard empty", 65'(exp_q_a.size() + exp_addr_a.size()), 65'(0));
        check("t2 done once", 65'($countones(tr_dn)), 65'(1));

        // Full backpressure: credits stop issue after FIFO_DEPTH reads.
        m_ready_a = 0;
        e0 = enb_cnt_a;
        issue_a(8'h30, 5);
        trace_a(12);
        check("t3 stalled enb count", 65'(enb_cnt_a - e0), 65'(4));
        m_ready_a = 1;
        got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (done_a) got = 1;
            @(posedge clk);
            #1;
        end
        check("t3 done seen", 65'(got), 65'(1));
        check("t3 total enb", 65'(enb_cnt_a - e0), 65'(5));
        check("t3 scoreboard empty", 65'(exp_q_a.size()), 65'(0));

        // Zero-length command.
        issue_a(8'h20, 0);
        trace_a(6);
        check("t4 enb", 65'(tr_enb), 65'(0));
        check("t4 m_valid", 65'(tr_mv), 65'(0));
        check("t4 done cycle", 65'(tr_dn), 65'(win(1, 1)));

        // Reset with two words queued, then a clean command.
        m_ready_a = 0;
        issue_a(8'h50, 5);
        trace_a(4);
        rst = 1;
        #1;
        check_outputs_reset("t5 mid reset");
        exp_q_a.delete();
        exp_addr_a.delete();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        m_ready_a = 1;
        issue_a(8'h60, 3);
        trace_a(10);
        check("t5 enb after reset", 65'(tr_enb), 65'(win(1, 3)));
        check("t5 done after reset", 65'(tr_dn), 65'(win(6, 6)));
        check("t5 scoreboard empty", 65'(exp_q_a.size()), 65'(0));

        // Instance B: random backpressure and junk commands while busy.
        for (int c = 0; c < 3; c++) begin
            len  = (c == 0) ? 256 : int'($urandom_range(1, 256));
            base = 8'($urandom_range(0, 255));
            expect_cmd(0, base, len);
            cmd_base_b  = base;
            cmd_len_b   = 9'(len);
            cmd_valid_b = 1;
            @(posedge clk);
            #1;
            cmd_valid_b = 0;
            got = 0;
            for (int k = 0; k < 5000 && !got; k++) begin
                m_ready_b   = ($urandom_range(0, 2) != 0);
                junk_b      = busy_b && ($urandom_range(0, 5) == 0);
                cmd_valid_b = junk_b;
                cmd_base_b  = 8'($urandom);
                cmd_len_b   = 9'($urandom_range(0, 256));
                @(negedge clk);
                if (done_b) got = 1;
                @(posedge clk);
                #1;
            end
            junk_b      = 0;
            cmd_valid_b = 0;
            check("B done seen", 65'(got), 65'(1));
            check("B scoreboard empty", 65'(exp_q_b.size()), 65'(0));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
